// File: rtl/mulradix8_seq_param.sv
// mulradix8_seq_param: sequential radix-8 (modified Booth) multiplier.
// Each ITER cycle recodes 3 multiplier bits into a digit in {-4..+4} and
// adds digit*Multiplicand into a 2*WIDTH accumulator. Operands are signed
// or unsigned per operation. A start/busy/flag handshake frames each op.
// Optional build macro: MULRADIX8_EARLY_TERM_EN (stop iterating once every
// remaining multiplier digit is zero; the result is identical either way).
module mulradix8_seq_param #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   Multiplier,
    input  logic [WIDTH-1:0]   Multiplicand,
    output logic               busy,
    output logic               flag,
    output logic [2*WIDTH-1:0] Partial_product
);

    // Booth digits per operation: ceil((WIDTH+1)/3)
    localparam int ITER = (WIDTH + 3) / 3;
    localparam int PW   = 2 * WIDTH;
    // Multiplier shift register: bit -1 at the LSB, room for every digit window
    localparam int MQW  = 3 * ITER + 1;
    localparam int M3W  = WIDTH + 3;
    localparam int KW   = $clog2(ITER + 1);
    localparam int SW   = KW + 2;

`ifdef MULRADIX8_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_ITER = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic signed [MQW-1:0] mq_q, mq_d;
    logic signed [WIDTH:0] mc_q, mc_d;
    logic signed [M3W-1:0] m3_q, m3_d;
    logic [PW-1:0]         acc_q, acc_d;
    logic [PW-1:0]         pp_q, pp_d;

    logic signed [WIDTH+1:0] mseed;
    logic signed [MQW-1:0]   mq_next;
    logic [PW-1:0]           addend;
    logic [SW-1:0]           shamt;

    // digit*M sign-extended to the product width; window is {m[3k+2..3k-1]}
    function automatic logic [PW-1:0] booth_term(
        input logic [3:0]            bits,
        input logic signed [WIDTH:0] m1,
        input logic signed [M3W-1:0] m3
    );
        logic signed [PW-1:0] m1x;
        logic signed [PW-1:0] m3x;
        logic signed [PW-1:0] mag;
        m1x = PW'(m1);
        m3x = PW'(m3);
        case (bits)
            4'b0000, 4'b1111:                   mag = '0;
            4'b0001, 4'b0010, 4'b1101, 4'b1110: mag = m1x;
            4'b0011, 4'b0100, 4'b1011, 4'b1100: mag = m1x <<< 1;
            4'b0101, 4'b0110, 4'b1001, 4'b1010: mag = m3x;
            default:                            mag = m1x <<< 2;
        endcase
        return bits[3] ? -mag : mag;
    endfunction

    // Remaining digits are all zero exactly when the unconsumed window is uniform
    function automatic logic all_same(input logic [MQW-1:0] v);
        return (&v) | (~|v);
    endfunction

    // Next-state and datapath update for the handshake FSM
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        mq_d    = mq_q;
        mc_d    = mc_q;
        m3_d    = m3_q;
        acc_d   = acc_q;
        pp_d    = pp_q;

        mseed   = {is_signed & Multiplier[WIDTH-1], Multiplier, 1'b0};
        mq_next = mq_q >>> 3;
        addend  = booth_term(mq_q[3:0], mc_q, m3_q);
        shamt   = SW'({k_q, 1'b0}) + SW'(k_q);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mc_d    = {is_signed & Multiplicand[WIDTH-1], Multiplicand};
                    mq_d    = MQW'(mseed);
                    acc_d   = '0;
                    pp_d    = '0;
                    k_d     = '0;
                    state_d = S_PRE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRE: begin
                // 3M is the only hard multiple; computed once per operation
                m3_d = M3W'(mc_q) + (M3W'(mc_q) <<< 1);
                if (EARLY_TERM && all_same(mq_q)) begin
                    pp_d    = acc_q;
                    state_d = S_DONE;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                acc_d = acc_q + (addend << shamt);
                mq_d  = mq_next;
                k_d   = k_q + KW'(1);
                if ((k_q == KW'(ITER - 1)) || (EARLY_TERM && all_same(mq_next))) begin
                    pp_d    = acc_d;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            mq_q    <= '0;
            mc_q    <= '0;
            m3_q    <= '0;
            acc_q   <= '0;
            pp_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            mq_q    <= mq_d;
            mc_q    <= mc_d;
            m3_q    <= m3_d;
            acc_q   <= acc_d;
            pp_q    <= pp_d;
        end
    end

    assign busy            = (state_q == S_PRE) || (state_q == S_ITER);
    assign flag            = (state_q == S_DONE);
    assign Partial_product = pp_q;

endmodule

// File: tb/tb_mulradix8_seq_param.sv
// tb_mulradix8_seq_param: scoreboard bench for mulradix8_seq_param (WIDTH=32).
// Honours MULRADIX8_EARLY_TERM_EN for the expected latency.
module tb_mulradix8_seq_param;

    localparam int W    = 32;
    localparam int ITER = (W + 3) / 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           is_signed = 1'b0;
    logic [W-1:0]   mr = '0;
    logic [W-1:0]   md = '0;
    logic           busy;
    logic           flag;
    logic [2*W-1:0] pp;

    int cyc   = 0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [63:0] pp;
        int          sc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    mulradix8_seq_param #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .is_signed(is_signed),
        .Multiplier(mr),
        .Multiplicand(md),
        .busy(busy),
        .flag(flag),
        .Partial_product(pp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Exact product, modulo 2^64
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit sg);
        longint x;
        longint y;
        if (sg) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'b0, a});
            y = longint'({32'b0, b});
        end
        return 64'(x * y);
    endfunction

    // Start-to-flag latency
    function automatic int exp_lat(input logic [31:0] a, input bit sg);
`ifdef MULRADIX8_EARLY_TERM_EN
        longint v;
        longint s;
        v = sg ? longint'($signed(a)) : longint'({32'b0, a});
        if (v == 0) return 2;
        for (int k = 1; k < ITER; k++) begin
            s = v >>> (3 * k - 1);
            if (s == 0 || s == -1) return k + 2;
        end
        return ITER + 2;
`else
        return ITER + 2;
`endif
    endfunction

    // Monitor: every flag pulse retires one scoreboard entry
    always @(negedge clk) begin
        exp_t e;
        if (rst && flag) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_flag: got pp=%h with nothing outstanding", pp);
            end else begin
                e = sb.pop_front();
                chk("result", pp, e.pp);
                chk("latency", 64'(cyc - e.sc), 64'(e.lat));
            end
        end
    end

    // Issue one op from the current (negedge) phase; optionally pulse a stray start at cycle intr
    task automatic op(input logic [31:0] a, input logic [31:0] b, input bit sg, input int intr);
        int lat;
        lat       = exp_lat(a, sg);
        mr        = a;
        md        = b;
        is_signed = sg;
        start     = 1'b1;
        sb.push_back('{ref_mul(a, b, sg), cyc, lat});
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int j = 1; j <= lat; j++) begin
            @(negedge clk);
            if (j < lat) begin
                chk("busy", 64'(busy), 64'd1);
            end else begin
                chk("busy_done", 64'(busy), 64'd0);
                chk("flag", 64'(flag), 64'd1);
            end
            if (j == intr && j < lat - 1) begin
                start = 1'b1;
                mr    = 32'd9;
                md    = 32'd9;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_flag", 64'(flag), 64'd0);
        chk("reset_pp", pp, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        op(32'd5, 32'd7, 1'b1, 0);
        op(32'hFFFF_FFFB, 32'd7, 1'b1, 0);
        op(32'hFFFF_FFFB, 32'hFFFF_FFF5, 1'b1, 0);
        op(32'h7FF7_A099, 32'hF0F7_A099, 1'b1, 0);
        op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        @(negedge clk);
        op(32'd5, 32'd7, 1'b1, 1);
        op(32'd0, 32'd123, 1'b1, 0);
        op(32'hFFFF_FFFF, 32'd3, 1'b1, 0);
        op(32'h8000_0000, 32'h8000_0000, 1'b1, 0);

        // Abort an op with reset partway through
        mr        = 32'd1234567;
        md        = 32'd7654321;
        is_signed = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_flag", 64'(flag), 64'd0);
        chk("abort_pp", pp, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        op(32'hFFFF_FFFC, 32'd200, 1'b1, 0);

        for (int i = 0; i < 40; i++) begin
            op(pick(), pick(), 1'($urandom_range(0, 1)), 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("outstanding", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
